// File: rtl/velocity_cache_dbuf_multi.sv
// ----------------------------------------------------------------------------
// velocity_cache_dbuf_multi
//
// Double-buffered per-cell particle cache. One bank (the active bank) serves
// range-limited force reads while particles broadcast by the motion update
// unit are collected into the other (shadow) bank. When collection ends, the
// particle count is written to address 0 of the shadow bank and the banks
// swap. Up to two broadcast channels may be accepted per cycle.
//
// Ports:
//   clk                   clock
//   rst                   synchronous active-high reset
//   motion_update_enable  high for the whole collection phase
//   in_read_address       read address into the active bank
//   in_rden               read enable (2-cycle latency)
//   in_data               broadcast words {z,y,x}, channel 0 in the LSBs
//   in_data_dst_cell      per-channel destination cell {x,y,z}
//   in_data_valid         per-channel valid
//   out_particle_info     registered read data
//   out_particle_num      particle count of the active bank
//   out_active_bank       index of the active bank
//   out_update_done       one-cycle pulse when the banks swap
//   out_overflow          sticky: a particle was dropped in this/last update
// ----------------------------------------------------------------------------
module velocity_cache_dbuf_multi #(
    parameter int DATA_WIDTH    = 32,
    parameter int PARTICLE_NUM  = 220,
    parameter int ADDR_WIDTH    = 8,
    parameter int CELL_ID_WIDTH = 4,
    parameter int CELL_X        = 2,
    parameter int CELL_Y        = 2,
    parameter int CELL_Z        = 1,
    parameter int NUM_IN_CH     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 motion_update_enable,
    input  logic [ADDR_WIDTH-1:0]                in_read_address,
    input  logic                                 in_rden,
    input  logic [NUM_IN_CH*3*DATA_WIDTH-1:0]    in_data,
    input  logic [NUM_IN_CH*3*CELL_ID_WIDTH-1:0] in_data_dst_cell,
    input  logic [NUM_IN_CH-1:0]                 in_data_valid,
    output logic [3*DATA_WIDTH-1:0]              out_particle_info,
    output logic [ADDR_WIDTH-1:0]                out_particle_num,
    output logic                                 out_active_bank,
    output logic                                 out_update_done,
    output logic                                 out_overflow
);

    localparam int WORD_W = 3 * DATA_WIDTH;
    localparam int CELL_W = 3 * CELL_ID_WIDTH;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    // One extra bit so the saturated value PARTICLE_NUM+1 and the second
    // channel's address (up to PARTICLE_NUM+2) never wrap.
    localparam int CNT_W  = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(PARTICLE_NUM);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(PARTICLE_NUM + 1);

    localparam logic [CELL_ID_WIDTH-1:0] ID_X = CELL_ID_WIDTH'(CELL_X);
    localparam logic [CELL_ID_WIDTH-1:0] ID_Y = CELL_ID_WIDTH'(CELL_Y);
    localparam logic [CELL_ID_WIDTH-1:0] ID_Z = CELL_ID_WIDTH'(CELL_Z);
    localparam logic [CELL_W-1:0]        MY_CELL = {ID_X, ID_Y, ID_Z};

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE_NUM,
        SWAP
    } state_t;

    state_t state, state_next;

    // Advance the write counter, clamping at PARTICLE_NUM+1.
    function automatic logic [CNT_W-1:0] sat_advance(input logic [CNT_W-1:0] base,
                                                     input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
        if (sum > {1'b0, CNT_SAT}) begin
            return CNT_SAT;
        end
        return sum[CNT_W-1:0];
    endfunction

    logic                  active_bank;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_ch1;
    logic [CNT_W-1:0]      count_final;
    logic [1:0]            n_accept;

    logic                  collecting;
    logic                  starting;
    logic                  writing_num;
    logic                  swapping;

    logic [WORD_W-1:0]     data0;
    logic [WORD_W-1:0]     data1;
    logic                  match0;
    logic                  match1;
    logic                  wr0;
    logic                  wr1;
    logic                  drop;

    logic                  port_a_en;
    logic [ADDR_WIDTH-1:0] port_a_addr;
    logic [WORD_W-1:0]     port_a_data;
    logic                  port_b_en;
    logic [ADDR_WIDTH-1:0] port_b_addr;
    logic [WORD_W-1:0]     port_b_data;

    logic [WORD_W-1:0]     bank0 [DEPTH];
    logic [WORD_W-1:0]     bank1 [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_addr_p0;
    logic                  vld_p0;
    logic                  bank_p0;

    // Channel decode
    assign data0  = in_data[WORD_W-1:0];
    assign match0 = in_data_valid[0] && (in_data_dst_cell[CELL_W-1:0] == MY_CELL);

    generate
        if (NUM_IN_CH == 2) begin : g_ch1
            assign data1  = in_data[2*WORD_W-1:WORD_W];
            assign match1 = in_data_valid[1] &&
                            (in_data_dst_cell[2*CELL_W-1:CELL_W] == MY_CELL);
        end else begin : g_no_ch1
            assign data1  = '0;
            assign match1 = 1'b0;
        end
    endgenerate

    // FSM next-state and phase decode
    always_comb begin
        state_next  = state;
        collecting  = 1'b0;
        starting    = 1'b0;
        writing_num = 1'b0;
        swapping    = 1'b0;
        case (state)
            IDLE: begin
                if (motion_update_enable) begin
                    collecting = 1'b1;
                    starting   = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                // The cycle in which enable drops is still collected.
                collecting = 1'b1;
                if (!motion_update_enable) begin
                    state_next = WRITE_NUM;
                end
            end
            WRITE_NUM: begin
                writing_num = 1'b1;
                state_next  = SWAP;
            end
            SWAP: begin
                swapping   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write address generation: channel 1 lands right after channel 0 when
    // both are accepted; anything beyond PARTICLE_NUM is dropped.
    assign cnt_ch1     = cnt + CNT_W'(match0);
    assign count_final = cnt - CNT_ONE;
    assign n_accept    = {1'b0, match0} + {1'b0, match1};

    assign wr0  = collecting && match0 && (cnt <= CNT_LIMIT);
    assign wr1  = collecting && match1 && (cnt_ch1 <= CNT_LIMIT);
    assign drop = collecting && ((match0 && (cnt > CNT_LIMIT)) ||
                                 (match1 && (cnt_ch1 > CNT_LIMIT)));

    // Port A also carries the count word into address 0 during WRITE_NUM.
    assign port_a_en   = !rst && (wr0 || writing_num);
    assign port_a_addr = writing_num ? '0 : cnt[ADDR_WIDTH-1:0];
    assign port_a_data = writing_num ? WORD_W'(count_final) : data0;
    assign port_b_en   = !rst && wr1;
    assign port_b_addr = cnt_ch1[ADDR_WIDTH-1:0];
    assign port_b_data = data1;

    // Shadow bank writes: bank0 is the shadow when bank 1 is active.
    always_ff @(posedge clk) begin
        if (port_a_en && active_bank) begin
            bank0[port_a_addr] <= port_a_data;
        end
        if (port_b_en && active_bank) begin
            bank0[port_b_addr] <= port_b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (port_a_en && !active_bank) begin
            bank1[port_a_addr] <= port_a_data;
        end
        if (port_b_en && !active_bank) begin
            bank1[port_b_addr] <= port_b_data;
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            active_bank      <= 1'b0;
            cnt              <= CNT_ONE;
            out_particle_num <= '0;
            out_update_done  <= 1'b0;
            out_overflow     <= 1'b0;
        end else begin
            state           <= state_next;
            out_update_done <= swapping;
            if (collecting) begin
                cnt <= sat_advance(cnt, n_accept);
            end else if (swapping || (state == IDLE)) begin
                cnt <= CNT_ONE;
            end
            if (starting) begin
                out_overflow <= drop;
            end else if (drop) begin
                out_overflow <= 1'b1;
            end
            if (swapping) begin
                active_bank      <= ~active_bank;
                out_particle_num <= count_final[ADDR_WIDTH-1:0];
            end
        end
    end

    assign out_active_bank = active_bank;

    // Read stage p0: register the address and the bank it targets, so a
    // read issued before a swap still returns the old bank's data.
    always_ff @(posedge clk) begin
        rd_addr_p0 <= in_read_address;
        if (rst) begin
            vld_p0  <= 1'b0;
            bank_p0 <= 1'b0;
        end else begin
            vld_p0  <= in_rden;
            bank_p0 <= active_bank;
        end
    end

    // Read stage p1: registered RAM output, held while no read is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_particle_info <= '0;
        end else if (vld_p0) begin
            out_particle_info <= bank_p0 ? bank1[rd_addr_p0] : bank0[rd_addr_p0];
        end
    end

endmodule
